// File: rtl/triangle_bumper_ctrl.sv
// Shares one triangle renderer between three pinball bumpers: decodes pixel ownership,
// drives renderer inputs, attributes collisions and runs per-bumper hit/flash/cooldown FSMs.
module triangle_bumper_ctrl #(
    parameter int unsigned SIZE         = 128,
    parameter int unsigned UP_X         = 288,
    parameter int unsigned UP_Y         = 64,
    parameter int unsigned LEFT_X       = 32,
    parameter int unsigned LEFT_Y       = 300,
    parameter int unsigned RIGHT_X      = 480,
    parameter int unsigned RIGHT_Y      = 300,
    parameter int unsigned FLASH_FRAMES = 8,
    parameter int unsigned COOL_FRAMES  = 16,
    parameter logic [7:0]  HIT_RGB      = 8'hFF
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic        collision,
    input  logic [1:0]  level,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        InsideRectangle,
    output logic        is_up,
    output logic        is_left,
    output logic [7:0]  levelRGB,
    output logic        hitPulse,
    output logic [7:0]  hitCount
);

    localparam int unsigned PIX_W   = 11;
    localparam int unsigned CNT_MAX = (FLASH_FRAMES > COOL_FRAMES) ? FLASH_FRAMES : COOL_FRAMES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned N_BUMP  = 3;

    typedef enum logic [1:0] {OWN_NONE, OWN_UP, OWN_LEFT, OWN_RIGHT} owner_t;
    typedef enum logic [1:0] {ST_IDLE, ST_FLASH, ST_COOL} bump_state_t;

    // Bracket test done in 12 bits so corner+SIZE cannot wrap
    function automatic logic in_box(input logic [PIX_W-1:0] x, input logic [PIX_W-1:0] y,
                                    input int unsigned bx, input int unsigned by);
        logic [PIX_W:0] w_x;
        logic [PIX_W:0] w_y;
        w_x = {1'b0, x};
        w_y = {1'b0, y};
        return (w_x >= (PIX_W+1)'(bx)) && (w_x < (PIX_W+1)'(bx + SIZE)) &&
               (w_y >= (PIX_W+1)'(by)) && (w_y < (PIX_W+1)'(by + SIZE));
    endfunction

    logic              w_in_up;
    logic              w_in_left;
    logic              w_in_right;
    owner_t            w_owner;
    logic [PIX_W-1:0]  w_off_x;
    logic [PIX_W-1:0]  w_off_y;
    logic [7:0]        w_base_rgb;
    logic              w_own_flash;
    logic [N_BUMP-1:0] w_accept;
    logic [N_BUMP-1:0] w_flash;

    owner_t            r_own_d1;
    owner_t            r_own_d2;
    logic [PIX_W-1:0]  r_off_x;
    logic [PIX_W-1:0]  r_off_y;
    logic              r_inside;
    logic              r_is_up;
    logic              r_is_left;
    logic [7:0]        r_rgb;
    logic              r_hit_pulse;
    logic [7:0]        r_hit_cnt;

    assign w_in_up    = in_box(pixelX, pixelY, UP_X, UP_Y);
    assign w_in_left  = in_box(pixelX, pixelY, LEFT_X, LEFT_Y);
    assign w_in_right = in_box(pixelX, pixelY, RIGHT_X, RIGHT_Y);

    // Ownership with up > left > right priority; offsets relative to the owner's corner
    always_comb begin
        w_owner = OWN_NONE;
        w_off_x = '0;
        w_off_y = '0;
        if (w_in_up) begin
            w_owner = OWN_UP;
            w_off_x = pixelX - PIX_W'(UP_X);
            w_off_y = pixelY - PIX_W'(UP_Y);
        end else if (w_in_left) begin
            w_owner = OWN_LEFT;
            w_off_x = pixelX - PIX_W'(LEFT_X);
            w_off_y = pixelY - PIX_W'(LEFT_Y);
        end else if (w_in_right) begin
            w_owner = OWN_RIGHT;
            w_off_x = pixelX - PIX_W'(RIGHT_X);
            w_off_y = pixelY - PIX_W'(RIGHT_Y);
        end
    end

    always_comb begin
        w_base_rgb = 8'h1C;
        case (level)
            2'd0:    w_base_rgb = 8'h1C;
            2'd1:    w_base_rgb = 8'hE0;
            2'd2:    w_base_rgb = 8'h03;
            default: w_base_rgb = 8'hFC;
        endcase
    end

    always_comb begin
        w_own_flash = 1'b0;
        case (w_owner)
            OWN_UP:    w_own_flash = w_flash[0];
            OWN_LEFT:  w_own_flash = w_flash[1];
            OWN_RIGHT: w_own_flash = w_flash[2];
            default:   w_own_flash = 1'b0;
        endcase
    end

    // Renderer-facing stage plus the two-deep owner pipeline used for collision attribution
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_own_d1  <= OWN_NONE;
            r_own_d2  <= OWN_NONE;
            r_off_x   <= '0;
            r_off_y   <= '0;
            r_inside  <= 1'b0;
            r_is_up   <= 1'b0;
            r_is_left <= 1'b0;
            r_rgb     <= 8'h00;
        end else begin
            r_own_d1  <= w_owner;
            r_own_d2  <= r_own_d1;
            r_off_x   <= w_off_x;
            r_off_y   <= w_off_y;
            r_inside  <= (w_owner != OWN_NONE);
            r_is_up   <= (w_owner == OWN_UP);
            r_is_left <= (w_owner == OWN_LEFT);
            r_rgb     <= w_own_flash ? HIT_RGB : w_base_rgb;
        end
    end

    for (genvar g = 0; g < N_BUMP; g++) begin : g_bump
        bump_state_t      r_state;
        bump_state_t      w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             w_attr;
        logic             w_acc;

        assign w_attr = collision && (r_own_d2 == owner_t'(2'(g + 1)));

        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        // A hit in IDLE wins over a coincident startOfFrame: the full flash count is loaded
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_acc       = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_attr) begin
                        w_state_nxt = ST_FLASH;
                        w_cnt_nxt   = CNT_W'(FLASH_FRAMES);
                        w_acc       = 1'b1;
                    end
                end
                ST_FLASH: begin
                    if (startOfFrame) begin
                        if (r_cnt == CNT_W'(1)) begin
                            w_state_nxt = ST_COOL;
                            w_cnt_nxt   = CNT_W'(COOL_FRAMES);
                        end else begin
                            w_cnt_nxt = r_cnt - CNT_W'(1);
                        end
                    end
                end
                ST_COOL: begin
                    if (startOfFrame) begin
                        if (r_cnt == CNT_W'(1)) begin
                            w_state_nxt = ST_IDLE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        assign w_accept[g] = w_acc;
        assign w_flash[g]  = (r_state == ST_FLASH);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_hit_pulse <= 1'b0;
            r_hit_cnt   <= 8'h00;
        end else begin
            r_hit_pulse <= |w_accept;
            if ((|w_accept) && (r_hit_cnt != 8'hFF)) begin
                r_hit_cnt <= r_hit_cnt + 8'd1;
            end
        end
    end

    assign offsetX         = r_off_x;
    assign offsetY         = r_off_y;
    assign InsideRectangle = r_inside;
    assign is_up           = r_is_up;
    assign is_left         = r_is_left;
    assign levelRGB        = r_rgb;
    assign hitPulse        = r_hit_pulse;
    assign hitCount        = r_hit_cnt;

endmodule

// File: tb/tb_triangle_bumper_ctrl.sv
// Directed bench for triangle_bumper_ctrl: decode vectors from a table, then
// hand-written hit/flash/cooldown, reset and saturation sequences.
module tb_triangle_bumper_ctrl;

    logic        clk;
    logic        resetN;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        startOfFrame;
    logic        collision;
    logic [1:0]  level;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic        InsideRectangle;
    logic        is_up;
    logic        is_left;
    logic [7:0]  levelRGB;
    logic        hitPulse;
    logic [7:0]  hitCount;

    int n_tests = 0;
    int n_fail  = 0;

    triangle_bumper_ctrl dut (
        .clk            (clk),
        .resetN         (resetN),
        .pixelX         (pixelX),
        .pixelY         (pixelY),
        .startOfFrame   (startOfFrame),
        .collision      (collision),
        .level          (level),
        .offsetX        (offsetX),
        .offsetY        (offsetY),
        .InsideRectangle(InsideRectangle),
        .is_up          (is_up),
        .is_left        (is_left),
        .levelRGB       (levelRGB),
        .hitPulse       (hitPulse),
        .hitCount       (hitCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] x;
        logic [10:0] y;
        logic [1:0]  lvl;
        logic        ins;
        logic        up;
        logic        left;
        logic [10:0] ox;
        logic [10:0] oy;
        logic [7:0]  rgb;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_pix(input logic [10:0] x, input logic [10:0] y,
                           input logic [7:0] exp_rgb, input string nm);
        pixelX = x;
        pixelY = y;
        tick();
        chk(nm, 64'(levelRGB), 64'(exp_rgb));
    endtask

    task automatic sof_pulses(input int n);
        pixelX = 11'd0;
        pixelY = 11'd0;
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            tick();
        end
        startOfFrame = 1'b0;
    endtask

    // Pixel in the owner's bracket, then a collision two cycles later
    task automatic do_hit(input logic [10:0] x, input logic [10:0] y, input logic sof_in,
                          output logic pulse, output logic [7:0] cnt);
        pixelX = x;
        pixelY = y;
        tick();
        pixelX = 11'd0;
        pixelY = 11'd0;
        tick();
        collision    = 1'b1;
        startOfFrame = sof_in;
        tick();
        collision    = 1'b0;
        startOfFrame = 1'b0;
        pulse = hitPulse;
        cnt   = hitCount;
    endtask

    initial begin
        logic       p;
        logic [7:0] c;
        int         exp_cnt;

        //          x     y    lvl ins up left  ox    oy    rgb
        vecs[0]  = '{300,  70, 1, 1, 1, 0,  12,   6, 8'hE0};
        vecs[1]  = '{40,  310, 0, 1, 0, 1,   8,  10, 8'h1C};
        vecs[2]  = '{0,     0, 2, 0, 0, 0,   0,   0, 8'h03};
        vecs[3]  = '{500, 400, 3, 1, 0, 0,  20, 100, 8'hFC};
        vecs[4]  = '{287,  64, 0, 0, 0, 0,   0,   0, 8'h1C};
        vecs[5]  = '{415, 191, 1, 1, 1, 0, 127, 127, 8'hE0};
        vecs[6]  = '{416, 100, 1, 0, 0, 0,   0,   0, 8'hE0};
        vecs[7]  = '{159, 427, 2, 1, 0, 1, 127, 127, 8'h03};
        vecs[8]  = '{160, 300, 2, 0, 0, 0,   0,   0, 8'h03};
        vecs[9]  = '{480, 300, 3, 1, 0, 0,   0,   0, 8'hFC};
        vecs[10] = '{607, 427, 3, 1, 0, 0, 127, 127, 8'hFC};
        vecs[11] = '{300, 192, 0, 0, 0, 0,   0,   0, 8'h1C};

        resetN       = 1'b0;
        pixelX       = 11'd0;
        pixelY       = 11'd0;
        startOfFrame = 1'b0;
        collision    = 1'b0;
        level        = 2'd1;
        repeat (2) tick();
        chk("reset_outputs", 64'({offsetX, offsetY, InsideRectangle, is_up, is_left,
                                  levelRGB, hitPulse, hitCount}), 64'd0);
        resetN = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            pixelX = vecs[i].x;
            pixelY = vecs[i].y;
            level  = vecs[i].lvl;
            tick();
            chk($sformatf("decode_vec%0d", i),
                64'({InsideRectangle, is_up, is_left, offsetX, offsetY, levelRGB}),
                64'({vecs[i].ins, vecs[i].up, vecs[i].left, vecs[i].ox, vecs[i].oy, vecs[i].rgb}));
        end

        level = 2'd1;
        do_hit(11'd40, 11'd310, 1'b0, p, c);
        chk("hit1_pulse", 64'(p), 64'd1);
        chk("hit1_count", 64'(c), 64'd1);
        tick();
        chk("hit1_pulse_drop", 64'(hitPulse), 64'd0);
        chk_pix(11'd40,  11'd310, 8'hFF, "left_flash_now");
        chk_pix(11'd300, 11'd70,  8'hE0, "up_unaffected");
        chk_pix(11'd500, 11'd400, 8'hE0, "right_unaffected");

        do_hit(11'd40, 11'd310, 1'b0, p, c);
        chk("hit_in_flash_pulse", 64'(p), 64'd0);
        chk("hit_in_flash_count", 64'(c), 64'd1);
        sof_pulses(7);
        chk_pix(11'd40, 11'd310, 8'hFF, "left_flash_frame7");
        sof_pulses(1);
        chk_pix(11'd40, 11'd310, 8'hE0, "left_flash_end");

        do_hit(11'd40, 11'd310, 1'b0, p, c);
        chk("hit_in_cool_pulse", 64'(p), 64'd0);
        sof_pulses(15);
        do_hit(11'd40, 11'd310, 1'b0, p, c);
        chk("hit_cool15_pulse", 64'(p), 64'd0);
        chk("hit_cool15_count", 64'(c), 64'd1);
        sof_pulses(1);
        do_hit(11'd40, 11'd310, 1'b0, p, c);
        chk("hit2_pulse", 64'(p), 64'd1);
        chk("hit2_count", 64'(c), 64'd2);

        // Collision together with startOfFrame while IDLE
        do_hit(11'd500, 11'd400, 1'b1, p, c);
        chk("coinc_pulse", 64'(p), 64'd1);
        chk("coinc_count", 64'(c), 64'd3);
        chk_pix(11'd500, 11'd400, 8'hFF, "coinc_flash_now");
        sof_pulses(7);
        chk_pix(11'd500, 11'd400, 8'hFF, "coinc_flash_frame7");
        sof_pulses(1);
        chk_pix(11'd500, 11'd400, 8'hE0, "coinc_flash_end");

        // Asynchronous reset in the middle of a flash
        do_hit(11'd300, 11'd70, 1'b0, p, c);
        chk("up_hit_count", 64'(c), 64'd4);
        sof_pulses(3);
        chk_pix(11'd300, 11'd70, 8'hFF, "up_flash_before_reset");
        #2;
        resetN = 1'b0;
        #1;
        chk("async_reset_outputs", 64'({offsetX, offsetY, InsideRectangle, is_up, is_left,
                                        levelRGB, hitPulse, hitCount}), 64'd0);
        #1;
        resetN = 1'b1;
        pixelX = 11'd0;
        pixelY = 11'd0;
        collision = 1'b1;
        tick();
        collision = 1'b0;
        chk("coll_after_reset_pulse", 64'(hitPulse), 64'd0);
        chk("coll_after_reset_count", 64'(hitCount), 64'd0);
        chk_pix(11'd300, 11'd70, 8'hE0, "up_base_after_reset");

        // Up then left owners in consecutive cycles, collision held for both
        pixelX = 11'd300; pixelY = 11'd70;
        tick();
        pixelX = 11'd40;  pixelY = 11'd310;
        tick();
        pixelX = 11'd0;   pixelY = 11'd0;
        collision = 1'b1;
        tick();
        chk("consec_first", 64'({hitPulse, hitCount}), 64'({1'b1, 8'd1}));
        tick();
        collision = 1'b0;
        chk("consec_second", 64'({hitPulse, hitCount}), 64'({1'b1, 8'd2}));
        tick();
        chk("consec_after", 64'({hitPulse, hitCount}), 64'({1'b0, 8'd2}));

        exp_cnt = 2;
        for (int i = 0; i < 300; i++) begin
            do_hit(11'd500, 11'd400, 1'b0, p, c);
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            chk($sformatf("sat_hit%0d", i), 64'({p, c}), 64'({1'b1, 8'(exp_cnt)}));
            sof_pulses(24);
        end
        chk("sat_final", 64'(hitCount), 64'd255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/triangle_bumper_ctrl.md
# triangle_bumper_ctrl

Controller that lets three triangular pinball bumpers (up, left, right) share one triangle bitmap renderer. It decodes the current scan pixel, picks the owning bumper, and drives the renderer's offset, bracket, orientation and color inputs. It also attributes collisions back to the owning bumper and runs a per-bumper hit/flash/cooldown state machine that emits score pulses. It sits between the VGA pixel counters and the triangle renderer, alongside the ball/collision logic.

## Interface
Parameters:
- SIZE, 128: side of each bumper's square bracket, in pixels
- UP_X/UP_Y, 288/64: top-left corner of the up bumper
- LEFT_X/LEFT_Y, 32/300: top-left corner of the left bumper
- RIGHT_X/RIGHT_Y, 480/300: top-left corner of the right bumper
- FLASH_FRAMES, 8: number of frames a hit bumper is drawn in HIT_RGB
- COOL_FRAMES, 16: frames after a flash during which hits are ignored
- HIT_RGB, 8'hFF: flash color

Ports:
- clk  in  1  pixel clock
- resetN  in  1  asynchronous, active-low reset
- pixelX  in  11  current scan X
- pixelY  in  11  current scan Y
- startOfFrame  in  1  one-cycle pulse, once per frame
- collision  in  1  ball/triangle overlap at the renderer's *output* pixel
- level  in  2  game level, selects the base color
- offsetX  out  11  pixelX minus the owner's X corner (0 when no owner)
- offsetY  out  11  pixelY minus the owner's Y corner (0 when no owner)
- InsideRectangle  out  1  current pixel lies inside the owner's bracket
- is_up  out  1  owner is the up bumper
- is_left  out  1  owner is the left bumper
- levelRGB  out  8  color the renderer draws
- hitPulse  out  1  one-cycle pulse on each accepted hit
- hitCount  out  8  total accepted hits, saturates at 255

## Operation
Ownership decode:
- A bumper contains pixel (x,y) when X ≤ x < X+SIZE and Y ≤ y < Y+SIZE.
- If brackets overlap, priority is up > left > right.
- If no bumper contains the pixel, the owner is NONE.

Renderer outputs (stage 1, registered):
- Owner up: is_up=1, is_left=0.
- Owner left: is_up=0, is_left=1.
- Owner right: is_up=0, is_left=0.
- Owner NONE: all four of InsideRectangle, is_up, is_left and offsets are 0.

Base color by level:
- level 0 → 8'h1C
- level 1 → 8'hE0
- level 2 → 8'h03
- level 3 → 8'hFC

levelRGB is HIT_RGB if the owner is in FLASH, otherwise the base color.

Collision attribution:
- The owner ID is delayed 2 cycles: one for this block's register, one for the renderer register.
- A collision is attributed to the delayed owner. A collision while the delayed owner is NONE is ignored.

Per-bumper FSM (3 instances), states IDLE, FLASH, COOL:
- IDLE → FLASH on an attributed collision. Asserts hitPulse for one cycle, increments hitCount (saturating), loads frame counter with FLASH_FRAMES.
- FLASH: the counter decrements on each startOfFrame. When the counter is 1 and startOfFrame occurs, go to COOL and load COOL_FRAMES.
- COOL: the counter decrements on each startOfFrame. When the counter is 1 and startOfFrame occurs, return to IDLE.
- Collisions in FLASH or COOL are ignored.
- Collision and startOfFrame in the same cycle: both take effect. In IDLE the collision wins and the counter loads FLASH_FRAMES without decrementing.
- Hits on different bumpers in consecutive cycles are each accepted. hitPulse is the OR of per-bumper accept events. Accepts cannot coincide, because at most one owner exists per cycle.

Arithmetic:
- Offsets are 11-bit unsigned subtraction, valid only while InsideRectangle=1.
- hitCount does not wrap.

## Timing
- Reset (asynchronous, any time, including mid-FLASH): all outputs 0, levelRGB 8'h00, all FSMs IDLE, counters 0, owner pipeline cleared to NONE.
- Latency: pixel inputs → renderer-facing outputs is 1 cycle. Renderer output is 2 cycles after the pixel.
- Collision → hitPulse/hitCount update: 1 cycle (registered).
- Flash color change takes effect on the pixel after the accepted hit. It is therefore visible within the same frame.
- Flash lasts exactly FLASH_FRAMES startOfFrame pulses; cooldown lasts exactly COOL_FRAMES pulses.

## Test plan
- Reset, then scan pixel (300,70) with level=1 → after 1 cycle: InsideRectangle=1, is_up=1, offsetX=12, offsetY=6, levelRGB=8'hE0.
- Pixel (40,310) → is_left=1, offsetX=8, offsetY=10. Pixel (0,0) → InsideRectangle=0 and offsets 0.
- Collision pulse 2 cycles after a left-bumper pixel → hitPulse for 1 cycle, hitCount=1, left levelRGB=8'hFF for 8 frames, then base color. Up and right bumpers are unaffected.
- Second left collision during FLASH and during COOL → no hitPulse. Collision after 8+16 frames → accepted, hitCount=2.
- Collision coincident with startOfFrame in IDLE → accepted, and the flash still lasts a full 8 frames. Assert resetN mid-FLASH → all IDLE, hitCount=0, base color restored.
- 300 accepted hits, spaced beyond cooldown → hitCount holds at 255.
